// File: rtl/icache_dm_pkg.sv
// cache_pkg: shared line geometry and FSM states for the instruction cache
package cache_pkg;
  localparam int LINE_BITS  = 512;
  localparam int OFFSET_W   = 6;
  localparam int WORD_OFF_W = 3;
  typedef logic [LINE_BITS-1:0] line_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL} icache_state_t;
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and arbiter-side handshake bundles
interface icache_fetch_if #(parameter int ADDR_W = 64);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_rvalid;
  logic [63:0]       fetch_rdata;
  modport master(output fetch_valid, fetch_addr, fetch_flush, input fetch_ready, fetch_rvalid, fetch_rdata);
  modport slave(input fetch_valid, fetch_addr, fetch_flush, output fetch_ready, fetch_rvalid, fetch_rdata);
endinterface

interface icache_bus_if #(parameter int ADDR_W = 64);
  logic              irequest;
  logic              ireqack;
  logic [ADDR_W-1:0] iaddr;
  cache_pkg::line_t  idata;
  logic              idone;
  modport master(output irequest, iaddr, input ireqack, idata, idone);
  modport slave(input irequest, iaddr, output ireqack, idata, idone);
endinterface

// File: rtl/icache_dm_array.sv
// icache_array: data/tag/valid storage, combinational read and synchronous write at one index
module icache_array import cache_pkg::*; #(
  parameter int LINES = 64,
  parameter int TAG_W = 52,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_we,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  line_t            i_wr_line,
  input  logic             i_flush_all,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output line_t            o_line
);
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  line_t            r_data [LINES];
  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_valid <= '0;
    else if (i_flush_all) r_valid <= '0;
    else if (i_we) r_valid[i_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (i_we) begin
      r_tag[i_idx]  <= i_wr_tag;
      r_data[i_idx] <= i_wr_line;
    end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache; ICACHE_STATS_EN adds stat_hits/stat_misses
module icache_dm import cache_pkg::*; #(
  parameter int LINES  = 64,
  parameter int ADDR_W = 64
) (
  input  logic clk,
  input  logic reset,
  icache_fetch_if.slave f,
  icache_bus_if.master  b
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
  icache_state_t                r_state, w_next;
  logic [ADDR_W-1:WORD_OFF_W]   r_addr;
  logic [ADDR_W-1:0]            r_iaddr;
  logic                         r_drop, r_rvalid;
  logic [63:0]                  r_rdata, r_fill_word;
  logic                         w_valid, w_hit, w_fill, w_we;
  logic [TAG_W-1:0]             w_tag, w_rd_tag;
  logic [IDX_W-1:0]             w_idx;
  logic [WORD_OFF_W-1:0]        w_off;
  line_t                        w_line;
  assign w_off  = r_addr[OFFSET_W-1:WORD_OFF_W];
  assign w_idx  = r_addr[OFFSET_W+:IDX_W];
  assign w_tag  = r_addr[ADDR_W-1-:TAG_W];
  assign w_hit  = r_state == LOOKUP && w_valid && w_rd_tag == w_tag;
  assign w_fill = r_state == MISS_WAIT && b.idone;
  // a flush pending or arriving with idone keeps the line out of the array
  assign w_we   = w_fill && !r_drop && !f.fetch_flush;
  assign b.iaddr        = r_iaddr;
  assign f.fetch_rvalid = r_rvalid;
  assign f.fetch_rdata  = r_rdata;
  icache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk, .reset, .i_idx(w_idx), .i_we(w_we), .i_wr_tag(w_tag), .i_wr_line(b.idata),
    .i_flush_all(f.fetch_flush), .o_valid(w_valid), .o_tag(w_rd_tag), .o_line(w_line)
  );
  always_comb begin
    w_next        = r_state;
    f.fetch_ready = r_state == IDLE && reset;
    b.irequest    = r_state == MISS_REQ;
    unique case (r_state)
      IDLE:      w_next = f.fetch_valid ? LOOKUP : IDLE;
      LOOKUP:    w_next = w_hit ? IDLE : MISS_REQ;
      MISS_REQ:  w_next = b.ireqack ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: w_next = b.idone ? FILL : MISS_WAIT;
      FILL:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_iaddr     <= '0;
      r_drop      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_fill_word <= '0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_hit || r_state == FILL;
      r_drop   <= r_state == FILL ? 1'b0 : r_drop || (f.fetch_flush && (r_state == MISS_REQ || r_state == MISS_WAIT));
      if (f.fetch_valid && f.fetch_ready) r_addr <= f.fetch_addr[ADDR_W-1:WORD_OFF_W];
      if (r_state == LOOKUP && !w_hit) r_iaddr <= {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (w_fill) r_fill_word <= b.idata[{w_off, 6'd0}+:64];
      if (w_hit) r_rdata <= w_line[{w_off, 6'd0}+:64];
      else if (r_state == FILL) r_rdata <= r_fill_word;
    end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (!w_hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
    end
`endif
  a_ack_in_req: assert property (@(posedge clk) disable iff (!reset) b.ireqack |-> r_state == MISS_REQ);
  a_done_in_wait: assert property (@(posedge clk) disable iff (!reset) b.idone |-> r_state == MISS_WAIT);
endmodule
